// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths and FSM state encoding for the data-memory responder
package proc_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int WAIT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous single-port word RAM with per-byte write enables
module dmem_array
    import proc_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    output logic [WORD_WIDTH-1:0] o_rdata
);

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_rdata;

    // One access per enabled cycle: write selected byte lanes, or register the read word.
    // No reset here: memory contents must survive a controller reset.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-stage request/response FSM in front of dmem_array (option: DMEM_BYTE_EN)
module dmem_responder
    import proc_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_req_valid,
    input  logic                  i_req_we,
    input  logic [WORD_WIDTH-1:0] i_req_addr,
    input  logic [WORD_WIDTH-1:0] i_req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]            i_req_be,
`endif
    output logic                  o_req_ready,
    output logic                  o_rsp_valid,
    output logic [WORD_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

    dmem_state_t               r_state;
    dmem_state_t               w_next_state;
    logic [WAIT_CNT_WIDTH-1:0] r_cnt;
    logic [WAIT_CNT_WIDTH-1:0] w_next_cnt;

    logic                  r_we;
    logic [WORD_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [3:0]            r_be;

    logic                  w_accept;
    logic [3:0]            w_req_be;
    logic                  w_cur_we;
    logic [WORD_WIDTH-1:0] w_cur_addr;
    logic [WORD_WIDTH-1:0] w_cur_wdata;
    logic [3:0]            w_cur_be;
    logic                  w_cur_err;
    logic                  w_r_err;
    logic                  w_ram_en;
    logic [WORD_WIDTH-1:0] w_ram_rdata;

`ifdef DMEM_BYTE_EN
    assign w_req_be = i_req_be;
`else
    assign w_req_be = 4'hF;
`endif

    assign w_accept = i_req_valid && (r_state == IDLE);

    // With zero wait cycles the RAM access happens on the accept edge itself, so the
    // request is taken straight from the inputs while still in IDLE.
    assign w_cur_we    = (r_state == IDLE) ? i_req_we    : r_we;
    assign w_cur_addr  = (r_state == IDLE) ? i_req_addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? i_req_wdata : r_wdata;
    assign w_cur_be    = (r_state == IDLE) ? w_req_be    : r_be;
    assign w_cur_err   = (w_cur_addr >= 32'(DEPTH));
    assign w_r_err     = (r_addr >= 32'(DEPTH));

    // Next-state, wait counter and ready decode.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        o_req_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The RAM is touched only on the edge entering RESP; a reset on that same edge
    // cancels the access so an aborted store never commits.
    assign w_ram_en = (w_next_state == RESP) && i_reset_n && !w_cur_err;

    // State, counter and request capture registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_be    <= w_req_be;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_dmem_array (
        .i_clk  (i_clock),
        .i_en   (w_ram_en),
        .i_we   (w_cur_we),
        .i_be   (w_cur_be),
        .i_addr (w_cur_addr[ADDR_W-1:0]),
        .i_wdata(w_cur_wdata),
        .o_rdata(w_ram_rdata)
    );

    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_err   = o_rsp_valid && w_r_err;
    assign o_rsp_rdata = (o_rsp_valid && !r_we && !w_r_err) ? w_ram_rdata : '0;

endmodule
